execution: RTL and testbench
============================

Name: execution

Overview:
- EX stage of the 5-stage MIPS pipeline; sits between ID/EX and MEM.
- Performs the ALU operation selected by aluOp and funct, computes the word-addressed branch target, and selects the destination register.
- All results are captured in an EX/MEM output register, one cycle after the inputs are presented.

Parameters:
- none (widths fixed by the MIPS-32 ISA: data 32, word address 30, register index 5)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- aluOp  in  2  ALU class from control: 00 add, 01 sub, 10 R-type (funct decode), 11 or
- aluSrc  in  1  operand B select: 0 = readData2, 1 = sign-extended immediate
- regDst  in  1  destination select: 0 = dstReg1 (rt), 1 = dstReg2 (rd)
- readData1  in  32  register rs value (operand A)
- readData2  in  32  register rt value
- dstReg1  in  5  rt index
- dstReg2  in  5  rd index
- pc  in  30  word address of PC+4
- signExt  in  30  sign-extended immediate, word units; bits [5:0] = funct, [10:6] = shamt
- zero  out  1  registered: ALU result == 0
- branchdst  out  30  registered: pc + signExt
- aluRes  out  32  registered ALU result
- destReg  out  5  registered selected destination index

Behaviour:
- Reset:
  - rst_n low clears zero, branchdst, aluRes and destReg to 0 immediately, without waiting for a clock edge.
  - Outputs hold 0 until the first rising clk edge after rst_n returns high.
- Latency:
  - All outputs update on the rising clk edge and reflect the inputs sampled at that edge (1 cycle).
  - No handshake; a new operation is accepted every cycle.
- Operand B:
  - aluSrc=1: signExt sign-extended from bit 29 to 32 bits.
  - aluSrc=0: readData2.
- ALU control:
  - aluOp 00: A+B.
  - aluOp 01: A-B.
  - aluOp 11: A|B.
  - aluOp 10: decode funct = signExt[5:0]:
    - 100000 add; 100001 addu; 100010 sub; 100011 subu
    - 100100 and; 100101 or; 100110 xor; 100111 nor
    - 101010 slt (signed, result 0/1); 101011 sltu (unsigned)
    - 000000 sll B by shamt; 000010 srl; 000011 sra (arithmetic)
    - any other funct: add
- Arithmetic:
  - All add/sub wrap modulo 2^32.
  - No overflow exception or flag.
- zero: 1 iff the 32-bit combinational ALU result is all zeros, registered alongside aluRes.
- branchdst: pc + signExt, 30-bit modulo 2^30 (wraps); computed every cycle regardless of aluOp.
- destReg: regDst ? dstReg2 : dstReg1; computed every cycle.
- Reset asserted mid-operation: outputs clear at once; any in-flight result is lost.

Decomposition:
- Shared package mips_pkg holds:
  - aluOp encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_RTYPE=10, ALUOP_OR=11
  - funct constants: FUNCT_ADD, FUNCT_SUB, FUNCT_SLT, etc.
  - an enum alu_ctrl_t for the internal ALU operation
- One sub-module, alu_control: maps aluOp and funct to alu_ctrl_t.
- The ALU datapath, branch adder and output register stay in execution.

Test Plan:
- Reset: rst_n=0 after nonzero outputs -> all outputs 0 immediately, without waiting for clk.
- aluOp=10, aluSrc=1, readData1=2, signExt=34 (funct 100010 sub), pc=4, regDst=0, dstReg1=0:
  - after one edge: aluRes=0xFFFFFFE0, zero=0, branchdst=38, destReg=0.
- aluOp=01, aluSrc=0, readData1=readData2=0x1234, pc=100, signExt=0x3FFFFFFE (-2):
  - aluRes=0, zero=1, branchdst=98.
- aluOp=00, aluSrc=1, readData1=0x10, signExt=0x3FFFFFFC (-4), regDst=1, dstReg2=7:
  - aluRes=0x0C, destReg=7.
- R-type sweep, readData1=0x80000000, readData2=1:
  - slt=1; sltu=0; nor=0x7FFFFFFE.
  - sra with shamt 4 on readData2=0x80000000 -> 0xF8000000.
- Wrap: pc=0x3FFFFFFF, signExt=1 -> branchdst=0; readData1=0xFFFFFFFF plus B=1 (add) -> aluRes=0, zero=1.

Source files
------------

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Purpose : Shared definitions for the MIPS-32 EX stage: aluOp class encodings,
//           R-type funct codes, the internal ALU operation enum and a helper
//           that widens the 30-bit immediate to a 32-bit operand.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package mips_pkg;

   // ALU class driven by the main control unit
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   // R-type funct field codes
   localparam logic [5:0] FUNCT_SLL  = 6'b000000;
   localparam logic [5:0] FUNCT_SRL  = 6'b000010;
   localparam logic [5:0] FUNCT_SRA  = 6'b000011;
   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_ADDU = 6'b100001;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_SUBU = 6'b100011;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_XOR  = 6'b100110;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_SLTU = 6'b101011;

   // Internal ALU operation
   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_XOR,
      ALU_NOR,
      ALU_SLT,
      ALU_SLTU,
      ALU_SLL,
      ALU_SRL,
      ALU_SRA
   } alu_ctrl_t;

   // The immediate arrives already sign-extended to 30 bits; replicate bit 29
   // to reach the 32-bit datapath width.
   function automatic logic [31:0] sext30(input logic [29:0] v);
      return {{2{v[29]}}, v};
   endfunction

endpackage

// File: rtl/execution_if.sv
// -----------------------------------------------------------------------------
// execution_if
// Purpose : Bundles the ID/EX inputs and EX/MEM outputs of the EX stage.
// Signals : aluOp, aluSrc, regDst, readData1, readData2, dstReg1, dstReg2, pc,
//           signExt (driven by master) ; zero, branchdst, aluRes, destReg
//           (driven by slave, i.e. the execution stage).
// Modports: master - upstream/driver side, slave - execution stage.
// -----------------------------------------------------------------------------
interface execution_if;
   logic [1:0]  aluOp;
   logic        aluSrc;
   logic        regDst;
   logic [31:0] readData1;
   logic [31:0] readData2;
   logic [4:0]  dstReg1;
   logic [4:0]  dstReg2;
   logic [29:0] pc;
   logic [29:0] signExt;
   logic        zero;
   logic [29:0] branchdst;
   logic [31:0] aluRes;
   logic [4:0]  destReg;

   modport master (
      output aluOp, aluSrc, regDst, readData1, readData2, dstReg1, dstReg2,
             pc, signExt,
      input  zero, branchdst, aluRes, destReg
   );

   modport slave (
      input  aluOp, aluSrc, regDst, readData1, readData2, dstReg1, dstReg2,
             pc, signExt,
      output zero, branchdst, aluRes, destReg
   );
endinterface

// File: rtl/execution_alu_control.sv
// -----------------------------------------------------------------------------
// alu_control
// Purpose : Maps the control-unit ALU class and the R-type funct field to the
//           internal ALU operation. Purely combinational.
// Ports   : aluOp_i [1:0] ALU class, funct_i [5:0] funct field,
//           ctrl_o  alu_ctrl_t selected ALU operation.
// -----------------------------------------------------------------------------
module alu_control
   import mips_pkg::*;
(
   input  logic [1:0] aluOp_i,
   input  logic [5:0] funct_i,
   output alu_ctrl_t  ctrl_o
);

   always_comb begin
      ctrl_o = ALU_ADD;
      case (aluOp_i)
         ALUOP_ADD: ctrl_o = ALU_ADD;
         ALUOP_SUB: ctrl_o = ALU_SUB;
         ALUOP_OR:  ctrl_o = ALU_OR;
         default: begin
            // R-type: overflow-trapping and non-trapping variants share an op
            // because no overflow exception is raised.
            case (funct_i)
               FUNCT_ADD, FUNCT_ADDU: ctrl_o = ALU_ADD;
               FUNCT_SUB, FUNCT_SUBU: ctrl_o = ALU_SUB;
               FUNCT_AND:             ctrl_o = ALU_AND;
               FUNCT_OR:              ctrl_o = ALU_OR;
               FUNCT_XOR:             ctrl_o = ALU_XOR;
               FUNCT_NOR:             ctrl_o = ALU_NOR;
               FUNCT_SLT:             ctrl_o = ALU_SLT;
               FUNCT_SLTU:            ctrl_o = ALU_SLTU;
               FUNCT_SLL:             ctrl_o = ALU_SLL;
               FUNCT_SRL:             ctrl_o = ALU_SRL;
               FUNCT_SRA:             ctrl_o = ALU_SRA;
               default:               ctrl_o = ALU_ADD;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/execution.sv
// -----------------------------------------------------------------------------
// execution
// Purpose : EX stage of the 5-stage MIPS pipeline. Performs the ALU operation,
//           computes the word-addressed branch target and selects the
//           destination register; all results land in the EX/MEM register one
//           cycle after the inputs are presented.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, clears all outputs
//           bus   - execution_if.slave carrying ID/EX inputs and EX/MEM outputs
// -----------------------------------------------------------------------------
module execution
   import mips_pkg::*;
(
   input logic        clk,
   input logic        rst_n,
   execution_if.slave bus
);

   alu_ctrl_t          ctrl;
   logic        [31:0] op_b;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [31:0] sra_s;
   logic        [4:0]  shamt;

   logic        [31:0] alu_res_d, alu_res_q;
   logic               zero_d,    zero_q;
   logic        [29:0] branch_d,  branch_q;
   logic        [4:0]  dest_d,    dest_q;

   alu_control u_alu_control (
      .aluOp_i (bus.aluOp),
      .funct_i (bus.signExt[5:0]),
      .ctrl_o  (ctrl)
   );

   assign op_b  = bus.aluSrc ? sext30(bus.signExt) : bus.readData2;
   assign a_s   = $signed(bus.readData1);
   assign b_s   = $signed(op_b);
   assign shamt = bus.signExt[10:6];
   assign sra_s = b_s >>> shamt;

   always_comb begin
      alu_res_d = bus.readData1 + op_b;
      case (ctrl)
         ALU_ADD:  alu_res_d = bus.readData1 + op_b;
         ALU_SUB:  alu_res_d = bus.readData1 - op_b;
         ALU_AND:  alu_res_d = bus.readData1 & op_b;
         ALU_OR:   alu_res_d = bus.readData1 | op_b;
         ALU_XOR:  alu_res_d = bus.readData1 ^ op_b;
         ALU_NOR:  alu_res_d = ~(bus.readData1 | op_b);
         ALU_SLT:  alu_res_d = {31'd0, (a_s < b_s)};
         ALU_SLTU: alu_res_d = {31'd0, (bus.readData1 < op_b)};
         ALU_SLL:  alu_res_d = op_b << shamt;
         ALU_SRL:  alu_res_d = op_b >> shamt;
         ALU_SRA:  alu_res_d = sra_s;
         default:  alu_res_d = bus.readData1 + op_b;
      endcase
   end

   assign zero_d   = (alu_res_d == 32'd0);
   assign branch_d = bus.pc + bus.signExt;
   assign dest_d   = bus.regDst ? bus.dstReg2 : bus.dstReg1;

   // EX/MEM register boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_res_q <= '0;
         zero_q    <= 1'b0;
         branch_q  <= '0;
         dest_q    <= '0;
      end else begin
         alu_res_q <= alu_res_d;
         zero_q    <= zero_d;
         branch_q  <= branch_d;
         dest_q    <= dest_d;
      end
   end

   assign bus.aluRes    = alu_res_q;
   assign bus.zero      = zero_q;
   assign bus.branchdst = branch_q;
   assign bus.destReg   = dest_q;

endmodule

// File: tb/tb_execution.sv
module tb_execution;
   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   execution_if bus ();

   execution u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic        z;
      logic [29:0] bd;
      logic [31:0] res;
      logic [4:0]  dr;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, ".aluRes"},    bus.aluRes,           32'd0);
      chk({tag, ".zero"},      {31'd0, bus.zero},    32'd0);
      chk({tag, ".branchdst"}, {2'd0, bus.branchdst}, 32'd0);
      chk({tag, ".destReg"},   {27'd0, bus.destReg}, 32'd0);
   endtask

   // Drive one operation, push the bench-computed expectation, then pop and
   // compare once the EX/MEM register has captured it.
   task automatic step(input string tag, input logic [1:0] op, input logic src,
                       input logic rdst, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] d1, input logic [4:0] d2,
                       input logic [29:0] p, input logic [29:0] se,
                       input logic [31:0] eres, input logic [29:0] ebd,
                       input logic [4:0] edr);
      exp_t e;
      @(negedge clk);
      bus.aluOp     = op;
      bus.aluSrc    = src;
      bus.regDst    = rdst;
      bus.readData1 = a;
      bus.readData2 = b;
      bus.dstReg1   = d1;
      bus.dstReg2   = d2;
      bus.pc        = p;
      bus.signExt   = se;
      sb.push_back('{tag, (eres == 32'd0), ebd, eres, edr});
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() != 0)
      else begin
         errors++;
         $error("FAIL %s.sb: observed=empty expected=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, ".aluRes"},    bus.aluRes,            e.res);
         chk({e.tag, ".zero"},      {31'd0, bus.zero},     {31'd0, e.z});
         chk({e.tag, ".branchdst"}, {2'd0, bus.branchdst}, {2'd0, e.bd});
         chk({e.tag, ".destReg"},   {27'd0, bus.destReg},  {27'd0, e.dr});
      end
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic [29:0] rp, rs;
      errors = 0;
      checks = 0;
      bus.aluOp = 2'b00; bus.aluSrc = 1'b0; bus.regDst = 1'b0;
      bus.readData1 = 32'd0; bus.readData2 = 32'd0;
      bus.dstReg1 = 5'd0; bus.dstReg2 = 5'd0;
      bus.pc = 30'd0; bus.signExt = 30'd0;

      // Reset asserted before any clock edge
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      check_all_zero("rst_init");
      bus.readData1 = 32'h55; bus.pc = 30'h11; bus.dstReg1 = 5'd3;
      @(posedge clk);
      #1;
      check_all_zero("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed operations
      step("rtype_sub", 2'b10, 1'b1, 1'b0, 32'd2, 32'd0, 5'd0, 5'd9, 30'd4, 30'd34,
           32'hFFFF_FFE0, 30'd38, 5'd0);
      step("sub_zero", 2'b01, 1'b0, 1'b0, 32'h1234, 32'h1234, 5'd3, 5'd9, 30'd100,
           30'h3FFF_FFFE, 32'd0, 30'd98, 5'd3);
      step("add_negimm", 2'b00, 1'b1, 1'b1, 32'h10, 32'd0, 5'd2, 5'd7, 30'd0,
           30'h3FFF_FFFC, 32'h0C, 30'h3FFF_FFFC, 5'd7);
      step("slt", 2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 5'd1, 5'd2, 30'd0, 30'h2A,
           32'd1, 30'h2A, 5'd1);
      step("sltu", 2'b10, 1'b0, 1'b1, 32'h8000_0000, 32'd1, 5'd1, 5'd2, 30'd0, 30'h2B,
           32'd0, 30'h2B, 5'd2);
      step("nor", 2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 5'd4, 5'd5, 30'd0, 30'h27,
           32'h7FFF_FFFE, 30'h27, 5'd4);
      step("and", 2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 5'd4, 5'd5, 30'd0, 30'h24,
           32'd0, 30'h24, 5'd4);
      step("or_f", 2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 5'd4, 5'd5, 30'd0, 30'h25,
           32'h8000_0001, 30'h25, 5'd4);
      step("xor", 2'b10, 1'b0, 1'b0, 32'h8000_0001, 32'd3, 5'd4, 5'd5, 30'd0, 30'h26,
           32'h8000_0002, 30'h26, 5'd4);
      step("sll", 2'b10, 1'b0, 1'b0, 32'd0, 32'd1, 5'd6, 5'd5, 30'd0, 30'h100,
           32'h10, 30'h100, 5'd6);
      step("srl", 2'b10, 1'b0, 1'b0, 32'd0, 32'h8000_0000, 5'd6, 5'd5, 30'd0, 30'h102,
           32'h0800_0000, 30'h102, 5'd6);
      step("sra", 2'b10, 1'b0, 1'b1, 32'd0, 32'h8000_0000, 5'd6, 5'd8, 30'd0, 30'h103,
           32'hF800_0000, 30'h103, 5'd8);

      // Reset asserted mid-cycle with nonzero outputs: clears at once
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid");
      @(posedge clk);
      #1;
      check_all_zero("rst_mid_hold");
      @(negedge clk);
      rst_n = 1'b1;

      step("funct_unknown_add", 2'b10, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd1,
           5'd2, 30'd0, 30'h3F, 32'd0, 30'h3F, 5'd1);
      step("aluop_or", 2'b11, 1'b0, 1'b0, 32'hF0, 32'h0F, 5'd10, 5'd11, 30'd8, 30'd8,
           32'hFF, 30'd16, 5'd10);
      step("subu", 2'b10, 1'b0, 1'b0, 32'd5, 32'd7, 5'd10, 5'd11, 30'd0, 30'h23,
           32'hFFFF_FFFE, 30'h23, 5'd10);
      step("addu", 2'b10, 1'b0, 1'b1, 32'd5, 32'd7, 5'd10, 5'd11, 30'd0, 30'h21,
           32'd12, 30'h21, 5'd11);
      step("wrap", 2'b00, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0, 5'd31, 5'd0, 30'h3FFF_FFFF,
           30'd1, 32'd0, 30'd0, 5'd31);

      // Random adds with register operand; expectations from plain modular sums
      for (int i = 0; i < 8; i++) begin
         ra = $urandom;
         rb = $urandom;
         rp = 30'($urandom);
         rs = 30'($urandom);
         step("rand_add", 2'b00, 1'b0, 1'(i), ra, rb, 5'(i), 5'(i + 16), rp, rs,
              ra + rb, rp + rs, (i % 2 == 1) ? 5'(i + 16) : 5'(i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
